// File: rtl/iua_packer.sv
// iua_packer: packs 1-4 byte RLE records into dense 32-bit words.
// Drops whole records on stall, flushes partial words on request/idle.
module iua_packer #(
  parameter int          TIMEOUT  = 1024,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_width,
  input  logic        in_valid,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic [31:0] out_data,
  output logic [1:0]  out_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [23:0]   acc_q, acc_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   odata_q, odata_d;
  logic [1:0]    olen_q, olen_d;
  logic          ovalid_q, ovalid_d;
  logic          fp_q, fp_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   drop_q, drop_d;

  logic          free;
  logic          freq;
  logic [2:0]    n;
  logic [2:0]    t;
  logic [31:0]   rec_m;
  logic [23:0]   acc_m;
  logic [31:0]   pad_w;
  logic [55:0]   cat;
  logic          load;
  logic          emit;
  logic          drop;
  logic [15:0]   drop_base;

  assign free = !ovalid_q | out_ready;
  assign n    = {1'b0, in_width} + 3'd1;
  assign t    = {1'b0, cnt_q} + n;
  assign freq = flush | fp_q | (idle_q == IDLE_MAX);

  // Lane masking: valid record bytes, valid acc bytes, padded flush word.
  always_comb begin
    rec_m = '0;
    acc_m = '0;
    pad_w = {4{PAD_BYTE}};
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n) rec_m[8*i +: 8] = in_data[8*i +: 8];
    end
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < cnt_q) begin
        acc_m[8*i +: 8] = acc_q[8*i +: 8];
        pad_w[8*i +: 8] = acc_q[8*i +: 8];
      end
    end
    cat = {32'b0, acc_m} | ({24'b0, rec_m} << {cnt_q, 3'b000});
  end

  // Next-state: append/emit/drop records, flush handling, counters.
  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    odata_d  = odata_q;
    olen_d   = olen_q;
    ovalid_d = ovalid_q;
    fp_d     = fp_q;
    idle_d   = idle_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    load     = 1'b0;
    emit     = 1'b0;
    drop     = 1'b0;

    if (in_valid) begin
      if (!t[2]) begin
        acc_d = cat[23:0];
        cnt_d = t[1:0];
      end else if (free) begin
        odata_d = cat[31:0];
        olen_d  = 2'd3;
        load    = 1'b1;
        acc_d   = cat[55:32];
        cnt_d   = t[1:0];
      end else begin
        drop = 1'b1;
      end
      if (flush) fp_d = 1'b1;
    end else if (freq) begin
      if (cnt_q == 2'd0) begin
        fp_d = 1'b0;
      end else if (free) begin
        odata_d = pad_w;
        olen_d  = cnt_q - 2'd1;
        load    = 1'b1;
        emit    = 1'b1;
        cnt_d   = 2'd0;
        fp_d    = 1'b0;
      end else begin
        fp_d = 1'b1;
      end
    end

    if (load) begin
      ovalid_d = 1'b1;
    end else if (ovalid_q && out_ready) begin
      ovalid_d = 1'b0;
    end

    if (in_valid || (cnt_q == 2'd0) || emit) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IW'(1);
    end

    drop_base = ovf_clr ? 16'd0 : drop_q;
    if (ovf_clr) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_base == 16'hFFFF) ? 16'hFFFF : drop_base + 16'd1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      odata_q  <= '0;
      olen_q   <= '0;
      ovalid_q <= 1'b0;
      fp_q     <= 1'b0;
      idle_q   <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      odata_q  <= odata_d;
      olen_q   <= olen_d;
      ovalid_q <= ovalid_d;
      fp_q     <= fp_d;
      idle_q   <= idle_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  assign out_data  = odata_q;
  assign out_len   = olen_q;
  assign out_valid = ovalid_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
